// File: rtl/ysyx_201979054_muldiv_seq_if.sv
// Handshake/operand bundle between execute stage and the sequential M-extension unit.
// Latency: none (wires only).
// Backpressure: o_busy high means i_start is ignored; the master holds off until o_busy drops.
//
// Signals: i_start/i_flush request and abort, i_alu_control op code, i_src_1/i_src_2
// operands, o_busy in-flight flag, o_done one-cycle completion pulse, o_result held result.
interface ysyx_201979054_muldiv_seq_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 5
);
  logic                     i_start;
  logic                     i_flush;
  logic [CONTROL_WIDTH-1:0] i_alu_control;
  logic [DATA_WIDTH-1:0]    i_src_1;
  logic [DATA_WIDTH-1:0]    i_src_2;
  logic                     o_busy;
  logic                     o_done;
  logic [DATA_WIDTH-1:0]    o_result;

  modport master (
    output i_start, i_flush, i_alu_control, i_src_1, i_src_2,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_flush, i_alu_control, i_src_1, i_src_2,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/ysyx_201979054_muldiv_seq.sv
// Iterative RV64 mul/div/rem unit: shared shift-add multiplier and restoring divider.
// Latency: accept edge to o_done is N+2 cycles (N=64, or 32 for W ops); 2 for special cases.
// Backpressure: o_busy high in CALC/FIXUP, i_start then ignored (no queueing); i_flush aborts.
//
// Ports: clk, arst (synchronous, active-high); bus (slave modport) carries i_start, i_flush,
// i_alu_control, i_src_1, i_src_2 in and o_busy, o_done, o_result out.
// Optional macro MULDIV_EARLY_OUT_EN: trivial operands (zero multiplicand/multiplier, or
// divisor magnitude above dividend magnitude) skip CALC and finish in 2 cycles.
module ysyx_201979054_muldiv_seq #(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        arst,
  ysyx_201979054_muldiv_seq_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int WW = WORD_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CONTROL_WIDTH-1:0] OP_DIVW  = CONTROL_WIDTH'(5'b10011);
  localparam logic [CONTROL_WIDTH-1:0] OP_MULW  = CONTROL_WIDTH'(5'b10100);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIVU  = CONTROL_WIDTH'(5'b10101);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIVUW = CONTROL_WIDTH'(5'b10110);
  localparam logic [CONTROL_WIDTH-1:0] OP_REMU  = CONTROL_WIDTH'(5'b10111);
  localparam logic [CONTROL_WIDTH-1:0] OP_REMUW = CONTROL_WIDTH'(5'b11000);
  localparam logic [CONTROL_WIDTH-1:0] OP_REMW  = CONTROL_WIDTH'(5'b11001);
  localparam logic [CONTROL_WIDTH-1:0] OP_REM   = CONTROL_WIDTH'(5'b11010);
  localparam logic [CONTROL_WIDTH-1:0] OP_MUL   = CONTROL_WIDTH'(5'b11011);

  logic [1:0]    state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;       // multiplicand / dividend-then-quotient
  logic [DW-1:0] b_q, b_d;       // multiplier / divisor
  logic [DW:0]   acc_q, acc_d;   // product / partial remainder / special result
  logic          mul_q, mul_d, quo_q, quo_d, w_q, w_d;
  logic          special_q, special_d, neg_q, neg_d, done_q, done_d;
  logic [DW-1:0] result_q, result_d;

  // ---------------- decode and operand prep (used only at accept) ----------------
  logic [CONTROL_WIDTH-1:0] op;
  logic dec_mul, dec_quo, dec_rem, dec_w, dec_signed, dec_valid;
  assign op         = bus.i_alu_control;
  assign dec_mul    = (op == OP_MUL) || (op == OP_MULW);
  assign dec_quo    = (op == OP_DIVW) || (op == OP_DIVU) || (op == OP_DIVUW);
  assign dec_rem    = (op == OP_REMU) || (op == OP_REMUW) || (op == OP_REMW) || (op == OP_REM);
  assign dec_w      = (op == OP_DIVW) || (op == OP_MULW) || (op == OP_DIVUW) ||
                      (op == OP_REMUW) || (op == OP_REMW);
  assign dec_signed = (op == OP_DIVW) || (op == OP_REMW) || (op == OP_REM);
  assign dec_valid  = dec_mul || dec_quo || dec_rem;

  logic [DW-1:0] src1_w, src2_w, op1, op2, mag1, mag2, min_neg;
  logic          sign1, sign2;
  assign src1_w = dec_signed ? {{(DW-WW){bus.i_src_1[WW-1]}}, bus.i_src_1[WW-1:0]}
                             : {{(DW-WW){1'b0}}, bus.i_src_1[WW-1:0]};
  assign src2_w = dec_signed ? {{(DW-WW){bus.i_src_2[WW-1]}}, bus.i_src_2[WW-1:0]}
                             : {{(DW-WW){1'b0}}, bus.i_src_2[WW-1:0]};
  assign op1    = dec_w ? src1_w : bus.i_src_1;
  assign op2    = dec_w ? src2_w : bus.i_src_2;
  assign sign1  = dec_signed && op1[DW-1];
  assign sign2  = dec_signed && op2[DW-1];
  assign mag1   = sign1 ? -op1 : op1;
  assign mag2   = sign2 ? -op2 : op2;
  // Most-negative value as it appears after W sign extension.
  assign min_neg = dec_w ? {{(DW-WW+1){1'b1}}, {(WW-1){1'b0}}} : {1'b1, {(DW-1){1'b0}}};

  logic div_zero, div_ovf, early_mul, early_div, dec_special;
  assign div_zero = (dec_quo || dec_rem) && (op2 == '0);
  assign div_ovf  = dec_signed && (op1 == min_neg) && (op2 == {DW{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
  assign early_mul = dec_mul && ((op1 == '0) || (op2 == '0));
  assign early_div = (dec_quo || dec_rem) && (mag2 > mag1);
`else
  assign early_mul = 1'b0;
  assign early_div = 1'b0;
`endif
  assign dec_special = !dec_valid || div_zero || div_ovf || early_mul || early_div;

  logic [DW-1:0] special_res;
  always_comb begin
    special_res = '0;
    if (!dec_valid)     special_res = '0;
    else if (div_zero)  special_res = dec_quo ? {DW{1'b1}} : op1;
    else if (div_ovf)   special_res = dec_quo ? op1 : '0;
    else if (early_div) special_res = dec_quo ? '0 : op1;
    else                special_res = '0;
  end

  // ---------------- one iteration of each datapath ----------------
  logic [DW:0] mul_sum, r_shift, r_diff;
  assign mul_sum = acc_q + (b_q[0] ? {1'b0, a_q} : {(DW+1){1'b0}});
  assign r_shift = {acc_q[DW-1:0], a_q[DW-1]};
  // Remainder is one bit wider so the borrow lands in r_diff[DW].
  assign r_diff  = r_shift - {1'b0, b_q};

  // ---------------- final sign fixup ----------------
  logic [DW-1:0] fix_raw, fix_signed, fix_final;
  assign fix_raw    = (quo_q && !special_q) ? a_q : acc_q[DW-1:0];
  assign fix_signed = neg_q ? -fix_raw : fix_raw;
  assign fix_final  = w_q ? {{(DW-WW){fix_signed[WW-1]}}, fix_signed[WW-1:0]} : fix_signed;

  // ---------------- next state ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mul_d     = mul_q;
    quo_d     = quo_q;
    w_d       = w_q;
    special_d = special_q;
    neg_d     = neg_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (bus.i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (bus.i_start) begin
            mul_d     = dec_mul;
            quo_d     = dec_quo;
            w_d       = dec_w;
            special_d = dec_special;
            cnt_d     = dec_special ? 7'd0 : (dec_w ? 7'(WW) : 7'(DW));
            if (dec_special) begin
              acc_d   = {1'b0, special_res};
              a_d     = '0;
              b_d     = '0;
              neg_d   = 1'b0;
              state_d = S_FIXUP;
            end else if (dec_mul) begin
              acc_d   = '0;
              a_d     = op1;
              b_d     = op2;
              neg_d   = 1'b0;
              state_d = S_CALC;
            end else begin
              acc_d   = '0;
              // W dividends sit in the top half so quotient bits fill the low half.
              a_d     = dec_w ? {mag1[WW-1:0], {(DW-WW){1'b0}}} : mag1;
              b_d     = mag2;
              neg_d   = dec_quo ? (sign1 ^ sign2) : sign1;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (mul_q) begin
            acc_d = mul_sum;
            a_d   = {a_q[DW-2:0], 1'b0};
            b_d   = {1'b0, b_q[DW-1:1]};
          end else begin
            acc_d = r_diff[DW] ? r_shift : r_diff;
            a_d   = {a_q[DW-2:0], ~r_diff[DW]};
          end
          cnt_d = (cnt_q == 7'd0) ? 7'd0 : cnt_q - 7'd1;
          if (cnt_d == 7'd0) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          result_d = fix_final;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mul_q     <= 1'b0;
      quo_q     <= 1'b0;
      w_q       <= 1'b0;
      special_q <= 1'b0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mul_q     <= mul_d;
      quo_q     <= quo_d;
      w_q       <= w_d;
      special_q <= special_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.o_done   = done_q;
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_ysyx_201979054_muldiv_seq.sv
// Directed bench for the sequential mul/div unit.
// Latency below is counted in falling edges after the accept edge until o_done is seen.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_ysyx_201979054_muldiv_seq;
  localparam logic [4:0] DIVW  = 5'b10011;
  localparam logic [4:0] MULW  = 5'b10100;
  localparam logic [4:0] DIVU  = 5'b10101;
  localparam logic [4:0] DIVUW = 5'b10110;
  localparam logic [4:0] REMU  = 5'b10111;
  localparam logic [4:0] REMUW = 5'b11000;
  localparam logic [4:0] REMW  = 5'b11001;
  localparam logic [4:0] REM   = 5'b11010;
  localparam logic [4:0] MUL   = 5'b11011;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ysyx_201979054_muldiv_seq_if #(.DATA_WIDTH(64), .CONTROL_WIDTH(5)) bus ();

  ysyx_201979054_muldiv_seq #(
    .DATA_WIDTH(64), .WORD_WIDTH(32), .CONTROL_WIDTH(5)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic launch(input logic [4:0] ctrl, input logic [63:0] s1, input logic [63:0] s2);
    bus.i_alu_control = ctrl;
    bus.i_src_1       = s1;
    bus.i_src_2       = s2;
    bus.i_start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [63:0] res);
    int n = 1;
    while (bus.o_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    res = bus.o_result;
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) seen++;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0; bus.i_alu_control = '0;
    bus.i_src_1 = '0; bus.i_src_2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    n_checks++; if (bus.o_result !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
  endtask

  task automatic test_divu_remu();
    int lat; logic [63:0] res;
    launch(DIVU, 64'd100, 64'd7); wait_done(lat, res);
    n_checks++; if (lat !== 66 || res !== 64'd14) begin n_fail++; $display("FAIL divu lat=%0d res=%h exp lat=66 res=%h", lat, res, 64'd14); end
    launch(REMU, 64'd100, 64'd7); wait_done(lat, res);
    n_checks++; if (lat !== 66 || res !== 64'd2) begin n_fail++; $display("FAIL remu lat=%0d res=%h exp lat=66 res=%h", lat, res, 64'd2); end
  endtask

  task automatic test_signed_overflow();
    int lat; logic [63:0] res;
    launch(DIVW, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL divw_ovf lat=%0d res=%h exp lat=2 res=ffffffff80000000", lat, res); end
    launch(REMW, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'd0) begin n_fail++; $display("FAIL remw_ovf lat=%0d res=%h exp lat=2 res=0", lat, res); end
  endtask

  task automatic test_div_by_zero();
    int lat; logic [63:0] res;
    launch(REM, 64'hFFFFFFFFFFFFFFFB, 64'd0); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'hFFFFFFFFFFFFFFFB) begin n_fail++; $display("FAIL rem_div0 lat=%0d res=%h exp lat=2 res=fffffffffffffffb", lat, res); end
    launch(DIVU, 64'd9, 64'd0); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL divu_div0 lat=%0d res=%h exp lat=2 res=ffffffffffffffff", lat, res); end
    launch(DIVUW, 64'h80000000, 64'd0); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL divuw_div0 lat=%0d res=%h exp lat=2 res=ffffffffffffffff", lat, res); end
    launch(REMUW, 64'h80000000, 64'd0); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL remuw_div0 lat=%0d res=%h exp lat=2 res=ffffffff80000000", lat, res); end
  endtask

  task automatic test_mul();
    int lat; logic [63:0] res;
    launch(MULW, 64'h7FFFFFFF, 64'd2); wait_done(lat, res);
    n_checks++; if (lat !== 34 || res !== 64'hFFFFFFFFFFFFFFFE) begin n_fail++; $display("FAIL mulw lat=%0d res=%h exp lat=34 res=fffffffffffffffe", lat, res); end
    launch(MUL, 64'hFFFFFFFFFFFFFFFD, 64'd5); wait_done(lat, res);
    n_checks++; if (lat !== 66 || res !== 64'hFFFFFFFFFFFFFFF1) begin n_fail++; $display("FAIL mul_neg lat=%0d res=%h exp lat=66 res=fffffffffffffff1", lat, res); end
  endtask

  task automatic test_signed_w();
    int lat; logic [63:0] res;
    launch(REMW, 64'hFFFFFFFFFFFFFFF9, 64'd2); wait_done(lat, res);
    n_checks++; if (lat !== 34 || res !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL remw lat=%0d res=%h exp lat=34 res=ffffffffffffffff", lat, res); end
    launch(DIVW, 64'hFFFFFFFFFFFFFFF9, 64'd2); wait_done(lat, res);
    n_checks++; if (lat !== 34 || res !== 64'hFFFFFFFFFFFFFFFD) begin n_fail++; $display("FAIL divw lat=%0d res=%h exp lat=34 res=fffffffffffffffd", lat, res); end
  endtask

  task automatic test_unsupported();
    int lat; logic [63:0] res;
    launch(5'b00001, 64'd123, 64'd456); wait_done(lat, res);
    n_checks++; if (lat !== 2 || res !== 64'd0) begin n_fail++; $display("FAIL unsupported lat=%0d res=%h exp lat=2 res=0", lat, res); end
  endtask

  task automatic test_ignore_busy();
    int n; int seen; logic [63:0] res;
    launch(DIVU, 64'd100, 64'd7);
    n = 1;
    while (bus.o_done !== 1'b1 && n < 200) begin
      if (n == 5) begin
        bus.i_alu_control = MUL; bus.i_src_1 = 64'd6; bus.i_src_2 = 64'd7; bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.i_start = 1'b0;
    res = bus.o_result;
    n_checks++; if (n !== 66 || res !== 64'd14) begin n_fail++; $display("FAIL ignore_busy lat=%0d res=%h exp lat=66 res=e", n, res); end
    count_done(80, seen);
    n_checks++; if (seen !== 0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_extra done_pulses=%0d busy=%b exp 0 and 0", seen, bus.o_busy); end
  endtask

  task automatic test_flush();
    int lat; int seen; logic [63:0] res;
    launch(DIVU, 64'd100, 64'd7);
    repeat (9) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got=%b exp=1", bus.o_busy); end
    bus.i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 64'd14) begin
      n_fail++; $display("FAIL flush_state busy=%b done=%b res=%h exp busy=0 done=0 res=e", bus.o_busy, bus.o_done, bus.o_result);
    end
    count_done(80, seen);
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done done_pulses=%0d exp=0", seen); end
    launch(MUL, 64'd6, 64'd7); wait_done(lat, res);
    n_checks++; if (lat !== 66 || res !== 64'd42) begin n_fail++; $display("FAIL flush_then_mul lat=%0d res=%h exp lat=66 res=2a", lat, res); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res;
    launch(MULW, 64'd6, 64'd7); wait_done(lat, res);
    n_checks++; if (lat !== 34 || res !== 64'd42 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first lat=%0d res=%h busy=%b exp lat=34 res=2a busy=0", lat, res, bus.o_busy);
    end
    // Start issued in the DONE cycle.
    launch(REMU, 64'd100, 64'd7); wait_done(lat, res);
    n_checks++; if (lat !== 66 || res !== 64'd2) begin n_fail++; $display("FAIL b2b_second lat=%0d res=%h exp lat=66 res=2", lat, res); end
  endtask

  task automatic test_early_out();
    int lat; logic [63:0] res; int exp_lat;
`ifdef MULDIV_EARLY_OUT_EN
    exp_lat = 2;
`else
    exp_lat = 66;
`endif
    launch(DIVU, 64'd3, 64'd10); wait_done(lat, res);
    n_checks++; if (lat !== exp_lat || res !== 64'd0) begin n_fail++; $display("FAIL early_divu lat=%0d res=%h exp lat=%0d res=0", lat, res, exp_lat); end
    launch(REMU, 64'd3, 64'd10); wait_done(lat, res);
    n_checks++; if (lat !== exp_lat || res !== 64'd3) begin n_fail++; $display("FAIL early_remu lat=%0d res=%h exp lat=%0d res=3", lat, res, exp_lat); end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    launch(MUL, 64'hFFFFFFFFFFFFFFFD, 64'd5);
    repeat (10) @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid busy=%b done=%b res=%h exp busy=0 done=0 res=0", bus.o_busy, bus.o_done, bus.o_result);
    end
    count_done(80, seen);
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_done done_pulses=%0d exp=0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divu_remu();
    test_signed_overflow();
    test_div_by_zero();
    test_mul();
    test_signed_w();
    test_unsupported();
    test_ignore_busy();
    test_flush();
    test_back_to_back();
    test_early_out();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
